// File: rtl/alu_adder_pipeline_pkg.sv
// Shared ALU constants: adder geometry defaults and the status-flag bit positions.
// Pure declarations, no logic; no latency or backpressure of its own.
package alu_adder_pipeline_pkg;

    localparam int ADD_WIDTH = 64;
    localparam int ADD_SLICE = 16;

    localparam int FLAG_W = 3;
    localparam int FLAG_C = 0;
    localparam int FLAG_V = 1;
    localparam int FLAG_Z = 2;

endpackage

// File: rtl/adder_pipe_slice.sv
// SLICE-bit adder: SLICE/4 CLA groups joined by a second-level lookahead on their G/P.
// Combinational, zero latency; no flow control.
module adder_pipe_slice #(
    parameter int SLICE = 16
) (
    input  logic [SLICE-1:0] a,
    input  logic [SLICE-1:0] b,
    input  logic             cin,
    output logic [SLICE-1:0] s,
    output logic             cout,
    output logic             c_msb
);

    localparam int NG = SLICE / 4;

    logic [NG-1:0] grp_g;
    logic [NG-1:0] grp_p;
    logic [NG:0]   grp_c;
    logic          grp_c3 [NG];

    for (genvar j = 0; j < NG; j++) begin : g_grp
        carry_lookahead_adder_4bit u_cla (
            .a   (a[4*j +: 4]),
            .b   (b[4*j +: 4]),
            .cin (grp_c[j]),
            .s   (s[4*j +: 4]),
            .g   (grp_g[j]),
            .p   (grp_p[j]),
            .c3  (grp_c3[j])
        );
    end

    // Group carries depend only on G/P and cin, never on the group sums.
    always_comb begin
        grp_c    = '0;
        grp_c[0] = cin;
        for (int j = 0; j < NG; j++) begin
            grp_c[j+1] = grp_g[j] | (grp_p[j] & grp_c[j]);
        end
    end

    assign cout  = grp_c[NG];
    assign c_msb = grp_c3[NG-1];

endmodule

// File: rtl/carry_lookahead_adder_4bit.sv
// 4-bit carry-lookahead adder exporting group generate/propagate and the carry into bit 3.
// Combinational, zero latency; no flow control.
module carry_lookahead_adder_4bit (
    input  logic [3:0] a,
    input  logic [3:0] b,
    input  logic       cin,
    output logic [3:0] s,
    output logic       g,
    output logic       p,
    output logic       c3
);

    logic [3:0] pi;
    logic [3:0] gi;
    logic [3:0] c;

    assign pi = a ^ b;
    assign gi = a & b;

    assign c = {
        gi[2] | (pi[2] & gi[1]) | (pi[2] & pi[1] & gi[0]) | (pi[2] & pi[1] & pi[0] & cin),
        gi[1] | (pi[1] & gi[0]) | (pi[1] & pi[0] & cin),
        gi[0] | (pi[0] & cin),
        cin
    };

    assign s  = pi ^ c;
    assign g  = gi[3] | (pi[3] & gi[2]) | (pi[3] & pi[2] & gi[1]) | (pi[3] & pi[2] & pi[1] & gi[0]);
    assign p  = &pi;
    assign c3 = c[3];

endmodule

// File: rtl/alu_adder_pipeline.sv
// Pipelined add/subtract, one SLICE resolved per stage with the carry rippled through registers.
// Latency WIDTH/SLICE cycles, 1 op/cycle; a stalled output freezes every stage (in_ready = !out_valid || out_ready).
module alu_adder_pipeline
    import alu_adder_pipeline_pkg::*;
#(
    parameter int WIDTH = ADD_WIDTH,
    parameter int SLICE = ADD_SLICE
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    input  logic             sub,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] s,
    output logic             cout,
    output logic             ovf,
    output logic             zero
);

    localparam int STAGES = WIDTH / SLICE;

    logic              en;
    logic [WIDTH-1:0]  b_eff;
    logic              c0;

    logic              vld_q [STAGES];
    logic [WIDTH-1:0]  a_q   [STAGES];
    logic [WIDTH-1:0]  b_q   [STAGES];
    logic [WIDTH-1:0]  s_q   [STAGES];
    logic              c_q   [STAGES];
    logic [FLAG_W-1:0] flags_q;

    logic [SLICE-1:0]  sl_s  [STAGES];
    logic              sl_c  [STAGES];
    logic              sl_m  [STAGES];
    logic [WIDTH-1:0]  s_d   [STAGES];

    assign en       = !out_valid || out_ready;
    assign in_ready = en;
    assign b_eff    = sub ? ~b : b;
    assign c0       = sub | cin;

    for (genvar k = 0; k < STAGES; k++) begin : g_stage
        if (k == 0) begin : g_first
            adder_pipe_slice #(.SLICE(SLICE)) u_slice (
                .a     (a[SLICE-1:0]),
                .b     (b_eff[SLICE-1:0]),
                .cin   (c0),
                .s     (sl_s[k]),
                .cout  (sl_c[k]),
                .c_msb (sl_m[k])
            );
        end else begin : g_next
            adder_pipe_slice #(.SLICE(SLICE)) u_slice (
                .a     (a_q[k-1][k*SLICE +: SLICE]),
                .b     (b_q[k-1][k*SLICE +: SLICE]),
                .cin   (c_q[k-1]),
                .s     (sl_s[k]),
                .cout  (sl_c[k]),
                .c_msb (sl_m[k])
            );
        end
    end

    // Each stage merges its freshly resolved slice into the partial sum from upstream.
    always_comb begin
        s_d[0]            = '0;
        s_d[0][SLICE-1:0] = sl_s[0];
        for (int k = 1; k < STAGES; k++) begin
            s_d[k]                  = s_q[k-1];
            s_d[k][k*SLICE +: SLICE] = sl_s[k];
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            for (int k = 0; k < STAGES; k++) begin
                vld_q[k] <= 1'b0;
                a_q[k]   <= '0;
                b_q[k]   <= '0;
                s_q[k]   <= '0;
                c_q[k]   <= 1'b0;
            end
            flags_q <= '0;
        end else if (en) begin
            vld_q[0] <= in_valid;
            a_q[0]   <= a;
            b_q[0]   <= b_eff;
            s_q[0]   <= s_d[0];
            c_q[0]   <= sl_c[0];
            for (int k = 1; k < STAGES; k++) begin
                vld_q[k] <= vld_q[k-1];
                a_q[k]   <= a_q[k-1];
                b_q[k]   <= b_q[k-1];
                s_q[k]   <= s_d[k];
                c_q[k]   <= sl_c[k];
            end
            flags_q[FLAG_C] <= sl_c[STAGES-1];
            flags_q[FLAG_V] <= sl_m[STAGES-1] ^ sl_c[STAGES-1];
            flags_q[FLAG_Z] <= (s_d[STAGES-1] == '0);
        end
    end

    assign out_valid = vld_q[STAGES-1];
    assign s         = s_q[STAGES-1];
    assign cout      = flags_q[FLAG_C];
    assign ovf       = flags_q[FLAG_V];
    assign zero      = flags_q[FLAG_Z];

endmodule

// File: tb/tb_alu_adder_pipeline.sv
// Scoreboard bench for alu_adder_pipeline: directed corner beats, stall and reset scenarios, then random traffic.
module tb_alu_adder_pipeline;

    localparam int W  = 64;
    localparam int ST = 4;

    logic         clk       = 1'b0;
    logic         rst       = 1'b1;
    logic         in_valid  = 1'b0;
    logic         in_ready;
    logic [W-1:0] a         = '0;
    logic [W-1:0] b         = '0;
    logic         cin       = 1'b0;
    logic         sub       = 1'b0;
    logic         out_valid;
    logic         out_ready = 1'b1;
    logic [W-1:0] s;
    logic         cout;
    logic         ovf;
    logic         zero;

    typedef struct packed {
        logic [W-1:0] s;
        logic         c;
        logic         v;
        logic         z;
    } res_t;

    res_t expq[$];
    int   checks   = 0;
    int   failures = 0;

    always #5 clk = ~clk;

    alu_adder_pipeline #(.WIDTH(W), .SLICE(16)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .a         (a),
        .b         (b),
        .cin       (cin),
        .sub       (sub),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .s         (s),
        .cout      (cout),
        .ovf       (ovf),
        .zero      (zero)
    );

    task automatic chk(input string name, input logic [W-1:0] got, input logic [W-1:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    // Reference: two's-complement arithmetic straight from the operation's meaning.
    function automatic res_t model(input logic [W-1:0] av, input logic [W-1:0] bv,
                                   input logic ci, input logic sb);
        res_t         r;
        logic [W:0]   full;
        if (sb) begin
            r.s = av - bv;
            r.c = (av >= bv);
            r.v = (av[W-1] != bv[W-1]) && (r.s[W-1] != av[W-1]);
        end else begin
            full = {1'b0, av} + {1'b0, bv} + {{W{1'b0}}, ci};
            r.s  = full[W-1:0];
            r.c  = full[W];
            r.v  = (av[W-1] == bv[W-1]) && (r.s[W-1] != av[W-1]);
        end
        r.z = (r.s == '0);
        return r;
    endfunction

    function automatic res_t mk(input logic [W-1:0] sv, input logic c, input logic v, input logic z);
        res_t r;
        r.s = sv; r.c = c; r.v = v; r.z = z;
        return r;
    endfunction

    task automatic step(input logic v, input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb, input logic ordy,
                        input res_t e, output logic took);
        @(negedge clk);
        in_valid  = v;
        a         = av;
        b         = bv;
        cin       = ci;
        sub       = sb;
        out_ready = ordy;
        #1;
        chk("in_ready", W'(in_ready), W'(!out_valid || out_ready));
        took = v && in_ready;
        if (took) expq.push_back(e);
    endtask

    task automatic idle(input int n);
        logic t;
        for (int i = 0; i < n; i++) step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, t);
    endtask

    task automatic send(input logic [W-1:0] av, input logic [W-1:0] bv,
                        input logic ci, input logic sb, input res_t e);
        logic t;
        t = 1'b0;
        for (int n = 0; n < 20 && !t; n++) step(1'b1, av, bv, ci, sb, 1'b1, e, t);
        if (!t) begin
            checks++; failures++;
            $display("FAIL send_timeout got=not_accepted exp=accepted");
        end
    endtask

    task automatic measure_latency(input string name);
        int   lat;
        logic t;
        lat = 0;
        do begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, t);
            lat++;
        end while (!out_valid && lat < 20);
        chk(name, W'(lat), W'(ST));
    endtask

    // Monitor: pops one expectation per output handshake and watches held outputs during stalls.
    initial begin
        logic held;
        res_t held_r;
        res_t e;
        held = 1'b0;
        held_r = '0;
        forever begin
            @(negedge clk);
            #2;
            if (rst) begin
                held = 1'b0;
                continue;
            end
            if (held && out_valid) begin
                chk("stall_s", s, held_r.s);
                chk("stall_flags", W'({cout, ovf, zero}), W'({held_r.c, held_r.v, held_r.z}));
            end
            if (out_valid && out_ready) begin
                if (expq.size() == 0) begin
                    checks++; failures++;
                    $display("FAIL unexpected_output got=s_%h exp=no_output", s);
                end else begin
                    e = expq.pop_front();
                    chk("s", s, e.s);
                    chk("cout", W'(cout), W'(e.c));
                    chk("ovf", W'(ovf), W'(e.v));
                    chk("zero", W'(zero), W'(e.z));
                end
                held = 1'b0;
            end else if (out_valid) begin
                if (!held) held_r = mk(s, cout, ovf, zero);
                held = 1'b1;
            end else begin
                held = 1'b0;
            end
        end
    end

    initial begin
        #300000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

    initial begin
        logic         t;
        int           i;
        int           stalls;
        logic [W-1:0] corner [4];
        logic [W-1:0] av;
        logic [W-1:0] bv;
        logic         ci;
        logic         sb;
        logic         ordy;
        logic         v;

        corner[0] = '0;
        corner[1] = '1;
        corner[2] = 64'h7FFF_FFFF_FFFF_FFFF;
        corner[3] = 64'h8000_0000_0000_0000;

        rst = 1'b1;
        repeat (3) @(negedge clk);
        #1;
        chk("rst_out_valid", W'(out_valid), '0);
        chk("rst_s", s, '0);
        chk("rst_flags", W'({cout, ovf, zero}), '0);
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        #1;
        chk("rst_in_ready", W'(in_ready), W'(1));

        // Single beat latency and value
        send(64'd1, 64'd1, 1'b0, 1'b0, mk(64'd2, 1'b0, 1'b0, 1'b0));
        measure_latency("latency_first");
        idle(2);

        // Corner beats back-to-back
        send(64'hFFFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0, mk('0, 1'b1, 1'b0, 1'b1));
        send(64'd5, 64'd7, 1'b0, 1'b1, mk(64'hFFFF_FFFF_FFFF_FFFE, 1'b0, 1'b0, 1'b0));
        send(64'd7, 64'd5, 1'b0, 1'b1, mk(64'd2, 1'b1, 1'b0, 1'b0));
        send(64'h7FFF_FFFF_FFFF_FFFF, 64'd1, 1'b0, 1'b0,
             mk(64'h8000_0000_0000_0000, 1'b0, 1'b1, 1'b0));
        send(64'd5, 64'd7, 1'b1, 1'b0, mk(64'd13, 1'b0, 1'b0, 1'b0));
        idle(8);
        chk("corner_drained", W'(expq.size()), '0);

        // Eight beats with a three-cycle output stall in the middle
        i = 0;
        stalls = 0;
        for (int cyc = 0; cyc < 24; cyc++) begin
            ordy = !(cyc >= 5 && cyc <= 7);
            step(i < 8, W'(i), W'(i), 1'b0, 1'b0, ordy,
                 mk(W'(2 * i), 1'b0, 1'b0, i == 0), t);
            if (!in_ready) stalls++;
            if (t) i++;
        end
        chk("stream_accepted", W'(i), W'(8));
        chk("stream_stalls", W'(stalls), W'(3));
        chk("stream_drained", W'(expq.size()), '0);

        // Reset with three beats in flight
        send(64'd10, 64'd1, 1'b0, 1'b0, mk(64'd11, 1'b0, 1'b0, 1'b0));
        send(64'd20, 64'd2, 1'b0, 1'b0, mk(64'd22, 1'b0, 1'b0, 1'b0));
        send(64'd30, 64'd3, 1'b0, 1'b0, mk(64'd33, 1'b0, 1'b0, 1'b0));
        @(negedge clk);
        in_valid = 1'b0;
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
        expq.delete();
        #1;
        chk("post_rst_out_valid", W'(out_valid), '0);
        stalls = 0;
        for (int n = 0; n < 8; n++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, t);
            if (out_valid) stalls++;
        end
        chk("post_rst_nothing_emerges", W'(stalls), '0);
        send(64'd3, 64'd4, 1'b0, 1'b0, mk(64'd7, 1'b0, 1'b0, 1'b0));
        measure_latency("latency_after_rst");
        idle(2);

        // Random traffic with random backpressure
        for (int n = 0; n < 400; n++) begin
            av = {$urandom, $urandom};
            bv = {$urandom, $urandom};
            if ($urandom_range(0, 7) == 0) av = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 7) == 0) bv = corner[$urandom_range(0, 3)];
            if ($urandom_range(0, 15) == 0) bv = av;
            ci   = 1'($urandom_range(0, 1));
            sb   = 1'($urandom_range(0, 1));
            v    = ($urandom_range(0, 9) < 7);
            ordy = ($urandom_range(0, 9) < 7);
            step(v, av, bv, ci, sb, ordy, model(av, bv, ci, sb), t);
        end
        for (int n = 0; n < 100 && expq.size() > 0; n++) begin
            step(1'b0, '0, '0, 1'b0, 1'b0, 1'b1, '0, t);
        end
        idle(2);
        chk("random_drained", W'(expq.size()), '0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
